// File: rtl/cmd_cfg_if.sv
// Command/response link between the UART wrapper (master) and the command
// interpreter (slave): incoming frame handshake plus outgoing response byte.
interface cmd_cfg_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cmd_cfg.sv
// Copter command interpreter: setpoint writes, spin-up/calibration sequencing
// and one-byte responses. Optional idle-thrust watchdog under CMD_WDOG_EN.
module cmd_cfg #(
  parameter bit FAST_SIM = 1'b1,
  parameter int WDOG_W   = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  cmd_cfg_if.slave          cif,
  input  logic [7:0]        batt,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]        thrst,
  output logic              strt_cal,
  output logic              inertial_cal,
  input  logic              cal_done,
  output logic              motors_off
);

  localparam int TMR_W = FAST_SIM ? 9 : 26;

  localparam logic [7:0] OP_REQ_BATT  = 8'h01;
  localparam logic [7:0] OP_SET_PTCH  = 8'h02;
  localparam logic [7:0] OP_SET_ROLL  = 8'h03;
  localparam logic [7:0] OP_SET_YAW   = 8'h04;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;
  localparam logic [7:0] RESP_ACK     = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPINUP = 3'd1,
    ST_CAL    = 3'd2,
    ST_RESP   = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         resp_q, resp_d;
  logic               clr_q, clr_d;
  logic               send_q, send_d;
  logic               strt_q, strt_d;
  logic               ical_q, ical_d;
  logic               moff_q, moff_d;
  logic [15:0]        ptch_q, ptch_d;
  logic [15:0]        roll_q, roll_d;
  logic [15:0]        yaw_q, yaw_d;
  logic [8:0]         thrst_q, thrst_d;
  logic               wdog_trip_s;

`ifdef CMD_WDOG_EN
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  // Watchdog counts idle cycles with nonzero thrust; trips once, then holds.
  always_comb begin
    wdog_d      = wdog_q;
    wdog_trip_s = 1'b0;
    if (clr_q) begin
      wdog_d = {WDOG_W{1'b0}};
    end else if ((state_q == ST_IDLE) && (thrst_q != 9'd0) && !(&wdog_q)) begin
      wdog_d      = wdog_q + WDOG_W'(1);
      wdog_trip_s = &wdog_d;
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= {WDOG_W{1'b0}};
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_trip_s = 1'b0;
  if (WDOG_W < 1) begin : g_wdog_w_unused
  end
`endif

  // Next-state, setpoint and pulse logic.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    resp_d  = resp_q;
    clr_d   = 1'b0;
    send_d  = 1'b0;
    strt_d  = 1'b0;
    ical_d  = ical_q;
    moff_d  = moff_q;
    ptch_d  = ptch_q;
    roll_d  = roll_q;
    yaw_d   = yaw_q;
    thrst_d = thrst_q;

    if (wdog_trip_s) begin
      ptch_d  = 16'd0;
      roll_d  = 16'd0;
      yaw_d   = 16'd0;
      thrst_d = 9'd0;
    end else begin
      thrst_d = thrst_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cif.cmd_rdy) begin
          clr_d   = 1'b1;
          state_d = ST_RESP;
          if (cif.cmd == OP_REQ_BATT) begin
            resp_d = batt;
          end else begin
            resp_d = RESP_ACK;
          end
          case (cif.cmd)
            OP_SET_PTCH:  ptch_d  = cif.data;
            OP_SET_ROLL:  roll_d  = cif.data;
            OP_SET_YAW:   yaw_d   = cif.data;
            OP_SET_THRST: thrst_d = cif.data[8:0];
            OP_CALIBRATE: begin
              state_d = ST_SPINUP;
              moff_d  = 1'b0;
              ical_d  = 1'b1;
              tmr_d   = {TMR_W{1'b0}};
            end
            OP_EMER_LAND: begin
              ptch_d  = 16'd0;
              roll_d  = 16'd0;
              yaw_d   = 16'd0;
              thrst_d = 9'd0;
            end
            OP_MTRS_OFF:  moff_d  = 1'b1;
            default:      state_d = ST_RESP;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPINUP: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (&tmr_q) begin
          strt_d  = 1'b1;
          state_d = ST_CAL;
        end else begin
          state_d = ST_SPINUP;
        end
      end
      ST_CAL: begin
        if (cal_done) begin
          ical_d  = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_CAL;
        end
      end
      ST_RESP: begin
        send_d  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cif.resp_sent) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= {TMR_W{1'b0}};
      resp_q  <= 8'h00;
      clr_q   <= 1'b0;
      send_q  <= 1'b0;
      strt_q  <= 1'b0;
      ical_q  <= 1'b0;
      moff_q  <= 1'b1;
      ptch_q  <= 16'd0;
      roll_q  <= 16'd0;
      yaw_q   <= 16'd0;
      thrst_q <= 9'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      resp_q  <= resp_d;
      clr_q   <= clr_d;
      send_q  <= send_d;
      strt_q  <= strt_d;
      ical_q  <= ical_d;
      moff_q  <= moff_d;
      ptch_q  <= ptch_d;
      roll_q  <= roll_d;
      yaw_q   <= yaw_d;
      thrst_q <= thrst_d;
    end
  end

  assign cif.clr_cmd_rdy = clr_q;
  assign cif.send_resp   = send_q;
  assign cif.resp        = resp_q;
  assign strt_cal        = strt_q;
  assign inertial_cal    = ical_q;
  assign motors_off      = moff_q;
  assign d_ptch          = ptch_q;
  assign d_roll          = roll_q;
  assign d_yaw           = yaw_q;
  assign thrst           = thrst_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Directed bench for cmd_cfg: setpoint opcodes, responses, calibrate timing,
// pending-frame handling, reset mid-sequence and (if enabled) the watchdog.
module tb_cmd_cfg;

`ifdef CMD_WDOG_EN
  localparam int WDOG_W = 8;
`else
  localparam int WDOG_W = 26;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  batt;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;
  logic        strt_cal, inertial_cal, cal_done, motors_off;

  int n_checks;
  int n_errors;

  cmd_cfg_if cif ();

  cmd_cfg #(.FAST_SIM(1'b1), .WDOG_W(WDOG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cif          (cif),
    .batt         (batt),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .strt_cal     (strt_cal),
    .inertial_cal (inertial_cal),
    .cal_done     (cal_done),
    .motors_off   (motors_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one simple command and walks it through RESP and WAIT.
  task automatic do_simple(input logic [7:0] op, input logic [15:0] dat, input logic [7:0] exp_resp);
    cif.cmd_rdy = 1'b1;
    cif.cmd     = op;
    cif.data    = dat;
    tick();
    check("clr_pulse", {31'd0, cif.clr_cmd_rdy}, 32'd1);
    check("send_early", {31'd0, cif.send_resp}, 32'd0);
    cif.cmd_rdy = 1'b0;
    tick();
    check("clr_single", {31'd0, cif.clr_cmd_rdy}, 32'd0);
    check("send_pulse", {31'd0, cif.send_resp}, 32'd1);
    check("resp_val", {24'd0, cif.resp}, {24'd0, exp_resp});
    tick();
    check("send_single", {31'd0, cif.send_resp}, 32'd0);
    check("resp_hold", {24'd0, cif.resp}, {24'd0, exp_resp});
    cif.resp_sent = 1'b1;
    tick();
    cif.resp_sent = 1'b0;
  endtask

  initial begin
    int  n;
    int  cnt;
    logic found;

    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    batt          = 8'h00;
    cal_done      = 1'b0;
    cif.cmd_rdy   = 1'b0;
    cif.cmd       = 8'h00;
    cif.data      = 16'h0000;
    cif.resp_sent = 1'b0;
    tick();
    tick();
    check("rst_thrst", {23'd0, thrst}, 32'd0);
    check("rst_moff", {31'd0, motors_off}, 32'd1);
    check("rst_send", {31'd0, cif.send_resp}, 32'd0);
    check("rst_resp", {24'd0, cif.resp}, 32'h00);
    check("rst_ptch", {16'd0, d_ptch}, 32'd0);
    check("rst_ical", {31'd0, inertial_cal}, 32'd0);
    check("rst_clr", {31'd0, cif.clr_cmd_rdy}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_simple(8'h05, 16'h01FF, 8'hA5);
    check("thrst_1ff", {23'd0, thrst}, 32'h1FF);

    do_simple(8'h03, 16'h0050, 8'hA5);
    do_simple(8'h02, 16'hFFB0, 8'hA5);
    check("roll_50", {16'd0, d_roll}, 32'h0050);
    check("ptch_m80", {16'd0, d_ptch}, 32'hFFB0);
    check("yaw_zero", {16'd0, d_yaw}, 32'h0000);

    // Calibrate; a cal_done during spin-up must be ignored.
    cif.cmd_rdy = 1'b1;
    cif.cmd     = 8'h06;
    cif.data    = 16'h0000;
    tick();
    cif.cmd_rdy = 1'b0;
    check("cal_moff", {31'd0, motors_off}, 32'd0);
    check("cal_ical", {31'd0, inertial_cal}, 32'd1);
    n     = 0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      n++;
      if (strt_cal) found = 1'b1;
      cal_done = (n == 100);
    end
    cal_done = 1'b0;
    check("strt_found", {31'd0, found}, 32'd1);
    check("strt_delay", n, 32'd512);
    tick();
    check("strt_single", {31'd0, strt_cal}, 32'd0);
    for (int i = 0; i < 99; i++) tick();
    check("ical_hold", {31'd0, inertial_cal}, 32'd1);
    check("cal_nosend", {31'd0, cif.send_resp}, 32'd0);
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    check("ical_fall", {31'd0, inertial_cal}, 32'd0);
    tick();
    check("cal_send", {31'd0, cif.send_resp}, 32'd1);
    check("cal_resp", {24'd0, cif.resp}, 32'hA5);
    tick();
    cif.resp_sent = 1'b1;
    tick();
    cif.resp_sent = 1'b0;

    batt = 8'hC3;
    do_simple(8'h01, 16'h0000, 8'hC3);
    do_simple(8'h05, 16'h0100, 8'hA5);
    check("thrst_100", {23'd0, thrst}, 32'h100);
    do_simple(8'h07, 16'h0000, 8'hA5);
    check("el_thrst", {23'd0, thrst}, 32'd0);
    check("el_ptch", {16'd0, d_ptch}, 32'd0);
    check("el_roll", {16'd0, d_roll}, 32'd0);
    check("el_yaw", {16'd0, d_yaw}, 32'd0);

    do_simple(8'h04, 16'h1234, 8'hA5);
    check("yaw_1234", {16'd0, d_yaw}, 32'h1234);
    do_simple(8'h3C, 16'hBEEF, 8'hA5);
    check("bad_op_yaw", {16'd0, d_yaw}, 32'h1234);
    check("bad_op_moff", {31'd0, motors_off}, 32'd0);
    do_simple(8'h08, 16'h0000, 8'hA5);
    check("mtrs_off", {31'd0, motors_off}, 32'd1);

    // Frame arriving during WAIT stays pending until the response is sent.
    cif.cmd_rdy = 1'b1;
    cif.cmd     = 8'h04;
    cif.data    = 16'h0011;
    tick();
    cif.cmd_rdy = 1'b0;
    tick();
    cif.cmd_rdy = 1'b1;
    cif.cmd     = 8'h03;
    cif.data    = 16'h7777;
    tick();
    check("pend_clr0", {31'd0, cif.clr_cmd_rdy}, 32'd0);
    tick();
    check("pend_clr1", {31'd0, cif.clr_cmd_rdy}, 32'd0);
    check("pend_roll", {16'd0, d_roll}, 32'd0);
    cif.resp_sent = 1'b1;
    tick();
    cif.resp_sent = 1'b0;
    check("pend_clr2", {31'd0, cif.clr_cmd_rdy}, 32'd0);
    tick();
    check("pend_take", {31'd0, cif.clr_cmd_rdy}, 32'd1);
    check("pend_roll2", {16'd0, d_roll}, 32'h7777);
    check("pend_yaw", {16'd0, d_yaw}, 32'h0011);
    cif.cmd_rdy = 1'b0;
    tick();
    check("pend_send", {31'd0, cif.send_resp}, 32'd1);
    tick();
    cif.resp_sent = 1'b1;
    tick();
    cif.resp_sent = 1'b0;

    // Reset asserted during spin-up.
    cif.cmd_rdy = 1'b1;
    cif.cmd     = 8'h06;
    tick();
    cif.cmd_rdy = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_moff", {31'd0, motors_off}, 32'd1);
    check("rst_mid_ical", {31'd0, inertial_cal}, 32'd0);
    check("rst_mid_roll", {16'd0, d_roll}, 32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (strt_cal || cif.send_resp) cnt++;
    end
    check("rst_mid_quiet", cnt, 32'd0);

`ifdef CMD_WDOG_EN
    do_simple(8'h05, 16'h0080, 8'hA5);
    check("wd_thrst80", {23'd0, thrst}, 32'h080);
    n   = 0;
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      n++;
      if (cif.send_resp) cnt++;
      if (thrst == 9'd0) found = 1'b1;
    end
    check("wd_trip", n, 32'd255);
    check("wd_nosend", cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_cfg.md
# cmd_cfg

Command interpreter sitting directly downstream of the copter-side UART wrapper. It consumes each 24-bit command frame (8-bit opcode plus 16-bit data), updates the flight setpoints, sequences motor spin-up and inertial calibration, and returns a one-byte response (positive acknowledge or battery level) through the same UART wrapper. Its setpoint outputs feed the flight controller and its calibration outputs drive the inertial interface.

## Interface
- FAST_SIM, default 1: 1 selects a 9-bit spin-up timer; 0 selects a 26-bit timer (about 1.34 s at 50 MHz).
- WDOG_W, default 26: width of the command-watchdog counter (used only with CMD_WDOG_EN).
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_rdy  in  1  a complete frame is held on cmd/data; held until cleared.
- cmd  in  8  opcode.
- data  in  16  command payload.
- clr_cmd_rdy  out  1  one-cycle pulse that consumes the current frame.
- resp  out  8  response byte; valid while send_resp is high.
- send_resp  out  1  one-cycle pulse that starts response transmission.
- resp_sent  in  1  response byte fully shifted out.
- batt  in  8  latest battery A2D reading.
- d_ptch, d_roll, d_yaw  out  16  signed desired pitch, roll, and yaw.
- thrst  out  9  desired thrust.
- strt_cal  out  1  one-cycle pulse that starts inertial calibration.
- inertial_cal  out  1  high from spin-up start until cal_done.
- cal_done  in  1  calibration finished.
- motors_off  out  1  forces the ESC outputs to zero.

## Operation
Opcodes:
- 0x01 REQ_BATT: resp = batt.
- 0x02 SET_PTCH: d_ptch = data.
- 0x03 SET_ROLL: d_roll = data.
- 0x04 SET_YAW: d_yaw = data.
- 0x05 SET_THRST: thrst = data[8:0]; data[15:9] are ignored.
- 0x06 CALIBRATE: runs the calibrate sequence below.
- 0x07 EMER_LAND: all setpoints and thrst cleared to 0.
- 0x08 MTRS_OFF: motors_off = 1.
- Any other opcode: clr_cmd_rdy is pulsed, nothing changes, and resp = 0xA5 is still sent.
- Every opcode except REQ_BATT responds with 0xA5.

State machine:
- IDLE → on cmd_rdy: latch opcode, pulse clr_cmd_rdy, apply the register write in the same cycle.
  - For CALIBRATE: go to SPINUP, clear motors_off, set inertial_cal, clear the timer.
  - For all other opcodes: go to RESP.
- SPINUP: timer increments each cycle. When the timer is all ones, pulse strt_cal and go to CAL.
- CAL: wait for cal_done. On cal_done, clear inertial_cal and go to RESP.
- RESP: pulse send_resp with resp valid, go to WAIT.
- WAIT: hold resp. On resp_sent, go to IDLE.

Command handling rules:
- cmd_rdy is ignored outside IDLE; the frame stays pending and is serviced on return to IDLE.
- Register writes use full width with no saturation.

## Timing
- Reset values:
  - d_ptch, d_roll, d_yaw, thrst = 0; resp = 0x00.
  - motors_off = 1.
  - clr_cmd_rdy, send_resp, strt_cal, inertial_cal = 0; state = IDLE.
- Latencies for simple opcodes:
  - cmd_rdy sampled high at edge N: clr_cmd_rdy and the setpoint update are visible after edge N.
  - send_resp is high after edge N+1.
  - Earliest next command is sampled at the edge after resp_sent.
- Spin-up lasts 2^9 cycles with FAST_SIM = 1, or 2^26 cycles with FAST_SIM = 0.
  - strt_cal is a single cycle.
  - If cal_done and resp_sent never arrive, the block stays in CAL or WAIT indefinitely.
- cal_done arriving in SPINUP is ignored.
- Asserting rst_n low mid-sequence returns every output to its reset value immediately; no response is sent.

## Configuration
- CMD_WDOG_EN defined:
  - A WDOG_W-bit counter clears on every clr_cmd_rdy and increments otherwise while the state is IDLE and thrst ≠ 0.
  - When the counter reaches all ones, all setpoints and thrst clear to 0, exactly as EMER_LAND but with no response sent.
  - The counter then holds until the next command.
- CMD_WDOG_EN undefined: the counter does not exist and setpoints hold indefinitely.

## Test plan
- Reset → thrst = 0, motors_off = 1, send_resp = 0. Then SET_THRST with data 0x01FF → thrst = 0x1FF, one clr_cmd_rdy pulse, resp = 0xA5, send_resp one cycle later.
- SET_ROLL with data 0x0050, then SET_PTCH with data 0xFFB0 → d_roll = 0x0050, d_ptch = 0xFFB0 (−80), d_yaw unchanged at 0; two 0xA5 responses.
- CALIBRATE with FAST_SIM = 1:
  - motors_off falls and inertial_cal rises.
  - strt_cal pulses exactly 512 cycles later.
  - cal_done pulsed 100 cycles after that → inertial_cal falls and resp = 0xA5 is sent.
- REQ_BATT with batt = 0xC3 → resp = 0xC3. Then EMER_LAND after thrust 0x100 → all setpoints = 0, resp = 0xA5.
- Second cmd_rdy asserted while in WAIT → no clr_cmd_rdy until resp_sent; afterwards it is serviced normally. rst_n pulsed low during SPINUP → motors_off = 1 and no strt_cal.
- With CMD_WDOG_EN and WDOG_W = 8: thrst = 0x80, then no commands → after 255 idle cycles thrst = 0 and no response is sent.
